// File: rtl/seq_bit_serializer_pkg.sv
// seq_pkg: shared types and width helpers for the bit serializer slice.
// The serializer state enum and the counter-width functions live here so
// the top and the bit timer size their counters the same way.
package seq_pkg;

   typedef enum logic [0:0] {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_t;

   // Width of the bit index that walks 0..word_w-1.
   function automatic int bidx_width(input int word_w);
      return $clog2(word_w);
   endfunction

   // Width of the hold counter that walks 0..bit_cycles-1.
   function automatic int cyc_width(input int bit_cycles);
      return $clog2(bit_cycles + 1);
   endfunction

endpackage

// File: rtl/seq_bit_serializer_timer.sv
// seq_bit_timer: per-bit hold counter for the serializer.
// cyc counts 0..BIT_CYCLES-1 while enabled and wraps; clear forces it to 0.
// cyc_wrap flags the current cycle as the last cycle of a bit. The
// bit_first_cycle / bit_last_cycle flags describe the cycle that starts at
// the next edge, so the serializer can register its strobe outputs.
module seq_bit_timer
   import seq_pkg::*;
#(
   parameter int BIT_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic cyc_wrap,
   output logic bit_first_cycle,
   output logic bit_last_cycle
);

   localparam int CYC_W = cyc_width(BIT_CYCLES);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] cyc_d;

   // Next hold count: clear wins, otherwise count and wrap while enabled.
   always_comb begin
      cyc_d = cyc_q;
      if (clear) begin
         cyc_d = {CYC_W{1'b0}};
      end else if (enable) begin
         if (cyc_q == CYC_LAST) begin
            cyc_d = {CYC_W{1'b0}};
         end else begin
            cyc_d = cyc_q + CYC_W'(1);
         end
      end else begin
         cyc_d = cyc_q;
      end
   end

   // Hold counter register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= {CYC_W{1'b0}};
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cyc_wrap        = (cyc_q == CYC_LAST);
   assign bit_first_cycle = (cyc_d == {CYC_W{1'b0}});
   assign bit_last_cycle  = (cyc_d == CYC_LAST);

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to serial bit stream, each bit held for
// BIT_CYCLES clocks, with gapless back-to-back words over valid/ready.
// Build option: define SEQ_SER_LSB_FIRST_EN to shift bit 0 out first
// (right shift); by default the MSB goes first (left shift).
// All outputs are registered except word_ready, which is decoded from the
// state and counters so a new word can be taken on the last bit cycle.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WORD_W     = 8,
   parameter int BIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              sequence_out,
   output logic              bit_valid,
   output logic              bit_strobe,
   output logic              busy,
   output logic              word_done
);

   localparam int BIDX_W = bidx_width(WORD_W);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_W - 1);
`ifdef SEQ_SER_LSB_FIRST_EN
   localparam int OUT_BIT = 0;
`else
   localparam int OUT_BIT = WORD_W - 1;
`endif

   ser_state_t        state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic              seq_out_q, seq_out_d;
   logic              bit_valid_q, bit_valid_d;
   logic              bit_strobe_q, bit_strobe_d;
   logic              busy_q, busy_d;
   logic              word_done_q, word_done_d;

   logic              ready_s;
   logic              accept_s;
   logic              last_slot_s;
   logic              timer_en_s;
   logic              cyc_wrap_s;
   logic              next_first_s;
   logic              next_last_s;

   seq_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_timer (
      .clock           (clock),
      .reset           (reset),
      .clear           (accept_s),
      .enable          (timer_en_s),
      .cyc_wrap        (cyc_wrap_s),
      .bit_first_cycle (next_first_s),
      .bit_last_cycle  (next_last_s)
   );

   // Handshake decode: ready when idle or in the final cycle of the last bit.
   always_comb begin
      timer_en_s  = (state_q == SER_SHIFT);
      last_slot_s = (state_q == SER_SHIFT) && (bidx_q == BIDX_LAST) && cyc_wrap_s;
      ready_s     = !reset && ((state_q == SER_IDLE) || last_slot_s);
      accept_s    = word_valid && ready_s;
   end

   assign word_ready = ready_s;

   // Next state, shift register and bit index.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      bidx_d  = bidx_q;
      case (state_q)
         SER_IDLE: begin
            if (accept_s) begin
               state_d = SER_SHIFT;
               sreg_d  = word_in;
               bidx_d  = {BIDX_W{1'b0}};
            end else begin
               state_d = SER_IDLE;
            end
         end
         SER_SHIFT: begin
            if (accept_s) begin
               state_d = SER_SHIFT;
               sreg_d  = word_in;
               bidx_d  = {BIDX_W{1'b0}};
            end else if (last_slot_s) begin
               state_d = SER_IDLE;
               sreg_d  = {WORD_W{1'b0}};
               bidx_d  = {BIDX_W{1'b0}};
            end else if (cyc_wrap_s) begin
               bidx_d = bidx_q + BIDX_W'(1);
`ifdef SEQ_SER_LSB_FIRST_EN
               sreg_d = {1'b0, sreg_q[WORD_W-1:1]};
`else
               sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
`endif
            end else begin
               state_d = SER_SHIFT;
            end
         end
         default: begin
            state_d = SER_IDLE;
            sreg_d  = {WORD_W{1'b0}};
            bidx_d  = {BIDX_W{1'b0}};
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state/counters.
   always_comb begin
      busy_d       = (state_d == SER_SHIFT);
      bit_valid_d  = busy_d;
      seq_out_d    = busy_d && sreg_d[OUT_BIT];
      bit_strobe_d = busy_d && next_first_s;
      word_done_d  = busy_d && (bidx_d == BIDX_LAST) && next_last_s;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= SER_IDLE;
         sreg_q       <= {WORD_W{1'b0}};
         bidx_q       <= {BIDX_W{1'b0}};
         seq_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         bit_strobe_q <= 1'b0;
         busy_q       <= 1'b0;
         word_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         bidx_q       <= bidx_d;
         seq_out_q    <= seq_out_d;
         bit_valid_q  <= bit_valid_d;
         bit_strobe_q <= bit_strobe_d;
         busy_q       <= busy_d;
         word_done_q  <= word_done_d;
      end
   end

   assign sequence_out = seq_out_q;
   assign bit_valid    = bit_valid_q;
   assign bit_strobe   = bit_strobe_q;
   assign busy         = busy_q;
   assign word_done    = word_done_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer. Two instances: BIT_CYCLES=2 and
// BIT_CYCLES=1. Each accepted word expands into one queue entry per held
// cycle {bit, strobe, done}; a monitor pops one entry per valid output cycle.
module tb_seq_bit_serializer;

   localparam int W   = 8;
   localparam int BC0 = 2;
   localparam int BC1 = 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset = 1'b1;
   logic [W-1:0] word_in0 = '0, word_in1 = '0;
   logic         wv0 = 1'b0, wv1 = 1'b0;
   logic         ready0, so0, bv0, bs0, busy0, wd0;
   logic         ready1, so1, bv1, bs1, busy1, wd1;

   int errors = 0;
   int checks = 0;
   logic [2:0] q0[$];
   logic [2:0] q1[$];
   logic [2:0] e0, e1;

   seq_bit_serializer #(.WORD_W(W), .BIT_CYCLES(BC0)) dut0 (
      .clock(clock), .reset(reset), .word_in(word_in0), .word_valid(wv0),
      .word_ready(ready0), .sequence_out(so0), .bit_valid(bv0),
      .bit_strobe(bs0), .busy(busy0), .word_done(wd0));

   seq_bit_serializer #(.WORD_W(W), .BIT_CYCLES(BC1)) dut1 (
      .clock(clock), .reset(reset), .word_in(word_in1), .word_valid(wv1),
      .word_ready(ready1), .sequence_out(so1), .bit_valid(bv1),
      .bit_strobe(bs1), .busy(busy1), .word_done(wd1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the n-th held cycle of word w, bits in transmit order.
   function automatic logic [2:0] exp_entry(input logic [W-1:0] w, input int bc, input int n);
      int b;
      int c;
      int k;
      b = n / bc;
      c = n % bc;
`ifdef SEQ_SER_LSB_FIRST_EN
      k = b;
`else
      k = W - 1 - b;
`endif
      return {w[k], (c == 0), (b == W - 1) && (c == bc - 1)};
   endfunction

   // One cycle of stimulus; pushes expectations for every accepted word.
   task automatic step(input logic rst, input logic v0, input logic [W-1:0] w0,
                       input logic v1, input logic [W-1:0] w1,
                       output logic acc0, output logic acc1);
      logic r0;
      logic r1;
      @(negedge clock);
      #1;
      reset = rst; wv0 = v0; word_in0 = w0; wv1 = v1; word_in1 = w1;
      if (rst) begin
         q0.delete();
         q1.delete();
      end
      #1;
      r0 = !rst && (q0.size() == 0);
      r1 = !rst && (q1.size() == 0);
      chk("d0_word_ready", ready0, r0);
      chk("d1_word_ready", ready1, r1);
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      if (acc0) for (int n = 0; n < W * BC0; n++) q0.push_back(exp_entry(w0, BC0, n));
      if (acc1) for (int n = 0; n < W * BC1; n++) q1.push_back(exp_entry(w1, BC1, n));
   endtask

   task automatic idle(input int cycles);
      logic a0, a1;
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
   endtask

   task automatic send0(input logic [W-1:0] w);
      logic a0, a1;
      int n;
      n = 0;
      do begin
         step(1'b0, 1'b1, w, 1'b0, '0, a0, a1);
         n++;
      end while (!a0 && n < 100);
      chk("d0_accept_bound", a0, 1'b1);
   endtask

   task automatic send1(input logic [W-1:0] w);
      logic a0, a1;
      int n;
      n = 0;
      do begin
         step(1'b0, 1'b0, '0, 1'b1, w, a0, a1);
         n++;
      end while (!a1 && n < 100);
      chk("d1_accept_bound", a1, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
         idle(1);
         n++;
      end
      chk("drain_bound", q0.size() + q1.size(), 0);
      idle(2);
   endtask

   // Monitor for the BIT_CYCLES=2 instance.
   always @(negedge clock) begin
      if (bv0) begin
         if (q0.size() == 0) begin
            chk("d0_unexpected_bit", 1'b1, 1'b0);
         end else begin
            e0 = q0.pop_front();
            chk("d0_sequence_out", so0, e0[2]);
            chk("d0_bit_strobe", bs0, e0[1]);
            chk("d0_word_done", wd0, e0[0]);
            chk("d0_busy", busy0, 1'b1);
         end
      end else begin
         chk("d0_missing_bit", q0.size(), 0);
         chk("d0_idle_seq", so0, 1'b0);
         chk("d0_idle_strobe", bs0, 1'b0);
         chk("d0_idle_done", wd0, 1'b0);
         chk("d0_idle_busy", busy0, 1'b0);
      end
   end

   // Monitor for the BIT_CYCLES=1 instance.
   always @(negedge clock) begin
      if (bv1) begin
         if (q1.size() == 0) begin
            chk("d1_unexpected_bit", 1'b1, 1'b0);
         end else begin
            e1 = q1.pop_front();
            chk("d1_sequence_out", so1, e1[2]);
            chk("d1_bit_strobe", bs1, e1[1]);
            chk("d1_word_done", wd1, e1[0]);
            chk("d1_busy", busy1, 1'b1);
         end
      end else begin
         chk("d1_missing_bit", q1.size(), 0);
         chk("d1_idle_seq", so1, 1'b0);
         chk("d1_idle_strobe", bs1, 1'b0);
         chk("d1_idle_done", wd1, 1'b0);
         chk("d1_idle_busy", busy1, 1'b0);
      end
   end

   initial begin
      logic a0, a1;
      // Reset for three cycles, then idle with word_valid low.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, a0, a1);
      idle(4);

      // Single word, then back to idle.
      send0(8'b0010_1100);
      drain();

      // Back-to-back words with valid held high.
      send0(8'hB0);
      send0(8'h0B);
      drain();

      // Reset in the middle of a word (around bit 3).
      send0(8'hFF);
      idle(3 * BC0 + 1);
      step(1'b1, 1'b0, '0, 1'b0, '0, a0, a1);
      idle(3);

      // BIT_CYCLES=1 instance: one bit per clock, strobe every cycle.
      send1(8'hA5);
      drain();

      // Word whose order depends on the bit-order build option.
      send0(8'h0D);
      send1(8'h0D);
      drain();

      // Random traffic on both instances, including junk while not ready.
      for (int i = 0; i < 120; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
              W'($urandom), a0, a1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
